// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and instruction constants
package cpu_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [5:0]  OP_RTYPE  = 6'h00;
  localparam logic [5:0]  OP_LW     = 6'h23;
  localparam logic [5:0]  OP_SW     = 6'h2B;
  localparam logic [5:0]  OP_BEQ    = 6'h04;
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load/flush and field slicing
module if_id_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc_plus4,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic [5:0]        id_op,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [5:0]        id_funct,
  output logic [15:0]       id_imm
);
  import cpu_pkg::*;

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;

  // Flush only drops the valid bit; the stale word stays visible but is marked invalid.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc4_d   = load_pc_plus4;
    end
  end

  // IF/ID state register, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;
  assign id_op       = instr_q[31:26];
  assign id_rs       = instr_q[25:21];
  assign id_rt       = instr_q[20:16];
  assign id_rd       = instr_q[15:11];
  assign id_funct    = instr_q[5:0];
  assign id_imm      = instr_q[15:0];

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - PC, fetch handshake FSM and skid buffer feeding IF/ID
module instr_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic [5:0]        id_op,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [5:0]        id_funct,
  output logic [15:0]       id_imm
);
  import cpu_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;

  logic              load;
  logic              flush;
  logic [31:0]       load_instr;
  logic [ADDR_W-1:0] load_pc4;
  logic [ADDR_W-1:0] pc_plus4;

  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign imem_req  = (state_q == FETCH) && !reset;
  assign imem_addr = pc_q;

  // Next-state: branch beats stall, stall beats ack; HOLD parks one word in the skid.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    load         = 1'b0;
    flush        = 1'b0;
    load_instr   = imem_rdata;
    load_pc4     = pc_plus4;
    if (branch_taken) begin
      pc_d         = {branch_target[ADDR_W-1:2], 2'b00};
      flush        = 1'b1;
      skid_instr_d = NOP_INSTR;
      skid_pc4_d   = '0;
      state_d      = FETCH;
    end else if (state_q == FETCH) begin
      if (stall) begin
        if (imem_ack) begin
          skid_instr_d = imem_rdata;
          skid_pc4_d   = pc_plus4;
          pc_d         = pc_plus4;
          state_d      = HOLD;
        end
      end else if (imem_ack) begin
        load = 1'b1;
        pc_d = pc_plus4;
      end else begin
        flush = 1'b1;
      end
    end else if (!stall) begin
      load       = 1'b1;
      load_instr = skid_instr_q;
      load_pc4   = skid_pc4_q;
      state_d    = FETCH;
    end
  end

  // PC, FSM and skid registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .flush        (flush),
    .load_instr   (load_instr),
    .load_pc_plus4(load_pc4),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .id_op        (id_op),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_funct     (id_funct),
    .id_imm       (id_imm)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc_plus4;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;

  logic        w_imem_req, w_id_valid;
  logic [31:0] w_imem_addr, w_id_instr, w_id_pc_plus4;
  logic [5:0]  w_id_op, w_id_funct;
  logic [4:0]  w_id_rs, w_id_rt, w_id_rd;
  logic [15:0] w_id_imm;

  int errors = 0;
  int checks = 0;

  // Reference model: fetched-but-undelivered words, PC and decode register contents.
  logic [63:0] pend[$];
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  instr_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .id_imm(id_imm)
  );

  instr_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc_plus4(w_id_pc_plus4),
    .id_op(w_id_op), .id_rs(w_id_rs), .id_rt(w_id_rt), .id_rd(w_id_rd),
    .id_funct(w_id_funct), .id_imm(w_id_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    pend.delete();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Drive one cycle of inputs and advance the model to what decode should see after the edge.
  task automatic drive(input logic st, input logic ak, input logic br,
                       input logic [31:0] tgt, input logic [31:0] rd);
    logic [63:0] e;
    logic        req_now;
    @(negedge clk);
    stall = st; imem_ack = ak; branch_taken = br;
    branch_target = tgt; imem_rdata = rd;
    req_now = (pend.size() == 0);
    if (br) begin
      pend.delete();
      m_valid = 1'b0;
      m_pc    = {tgt[31:2], 2'b00};
    end else begin
      if (ak && req_now) begin
        pend.push_back({rd, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
      if (!st) begin
        if (pend.size() > 0) begin
          e       = pend.pop_front();
          m_instr = e[63:32];
          m_pc4   = e[31:0];
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rdata = 32'h0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", id_pc_plus4); end
    checks++; if ({id_op, id_rs, id_rt, id_rd, id_funct, id_imm} !== 43'h0) begin errors++; $display("FAIL reset_fields: got nonzero field outputs"); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_release: req=%0b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h8C22_0004);
    checks++; if (id_valid !== 1'b1 || id_op !== 6'h23 || id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL stream_w0: valid=%0b op=%h pc4=%h want 1/23/4", id_valid, id_op, id_pc_plus4); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL stream_addr1: got %h want 4", imem_addr); end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hAC22_0008);
    checks++; if (id_valid !== 1'b1 || id_op !== 6'h2B || id_pc_plus4 !== 32'h8) begin errors++; $display("FAIL stream_w1: valid=%0b op=%h pc4=%h want 1/2b/8", id_valid, id_op, id_pc_plus4); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stream_addr2: got %h want 8", imem_addr); end
  endtask

  task automatic test_stall_skid();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0043_0820);
    checks++; if (id_instr !== 32'hAC22_0008 || id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: instr=%h valid=%0b want ac220008/1", id_instr, id_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %0b want 0", imem_req); end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    checks++; if (id_instr !== 32'hAC22_0008 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_ignore_ack: instr=%h req=%0b want ac220008/0", id_instr, imem_req); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (id_instr !== 32'h0043_0820 || id_valid !== 1'b1) begin errors++; $display("FAIL skid_release: instr=%h valid=%0b want 00430820/1", id_instr, id_valid); end
    checks++; if (id_rs !== 5'd2 || id_rt !== 5'd3 || id_rd !== 5'd1 || id_funct !== 6'h20) begin errors++; $display("FAIL skid_fields: rs=%0d rt=%0d rd=%0d funct=%h want 2/3/1/20", id_rs, id_rt, id_rd, id_funct); end
    checks++; if (id_pc_plus4 !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL skid_next: pc4=%h req=%0b addr=%h want c/1/c", id_pc_plus4, imem_req, imem_addr); end
  endtask

  task automatic test_branch_ack();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h1234_5678);
    checks++; if (id_valid !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL branch_ack: valid=%0b addr=%h req=%0b want 0/40/1", id_valid, imem_addr, imem_req); end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h1111_2222);
    checks++; if (id_valid !== 1'b1 || id_instr !== 32'h1111_2222 || id_pc_plus4 !== 32'h44) begin errors++; $display("FAIL branch_resume: valid=%0b instr=%h pc4=%h want 1/11112222/44", id_valid, id_instr, id_pc_plus4); end
  endtask

  task automatic test_branch_hold();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hBADB_AD00);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_enter: req=%0b want 0", imem_req); end
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL hold_branch: valid=%0b req=%0b addr=%h want 0/1/100", id_valid, imem_req, imem_addr); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL hold_no_stale: valid=%0b instr=%h want valid 0", id_valid, id_instr); end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0055);
    checks++; if (id_valid !== 1'b1 || id_instr !== 32'h55 || id_pc_plus4 !== 32'h104) begin errors++; $display("FAIL hold_resume: valid=%0b instr=%h pc4=%h want 1/55/104", id_valid, id_instr, id_pc_plus4); end
  endtask

  task automatic test_wrap();
    apply_reset();
    checks++; if (w_imem_addr !== 32'hFFFF_FFFC || w_imem_req !== 1'b1) begin errors++; $display("FAIL wrap_start: addr=%h req=%0b want fffffffc/1", w_imem_addr, w_imem_req); end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h8C22_0004);
    checks++; if (w_id_valid !== 1'b1 || w_id_pc_plus4 !== 32'h0 || w_imem_addr !== 32'h0) begin errors++; $display("FAIL wrap: valid=%0b pc4=%h addr=%h want 1/0/0", w_id_valid, w_id_pc_plus4, w_imem_addr); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h8C22_0004);
    @(negedge clk);
    imem_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL async_reset: req=%0b valid=%0b instr=%h want 0/0/0", imem_req, id_valid, id_instr); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL async_release: req=%0b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 16) == 0, $urandom, $urandom);
      checks++; if (imem_req !== (pend.size() == 0)) begin errors++; $display("FAIL rand_req[%0d]: got %0b want %0b", i, imem_req, pend.size() == 0); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rand_addr[%0d]: got %h want %h", i, imem_addr, m_pc); end
      checks++; if (id_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %0b want %0b", i, id_valid, m_valid); end
      checks++; if (id_instr !== m_instr || id_pc_plus4 !== m_pc4) begin errors++; $display("FAIL rand_ifid[%0d]: got %h/%h want %h/%h", i, id_instr, id_pc_plus4, m_instr, m_pc4); end
      checks++; if (id_op !== m_instr[31:26] || id_imm !== m_instr[15:0]) begin errors++; $display("FAIL rand_fields[%0d]: op=%h imm=%h want %h/%h", i, id_op, id_imm, m_instr[31:26], m_instr[15:0]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rdata = 32'h0;
    model_reset();
    test_reset();
    test_stream();
    test_stall_skid();
    test_branch_ack();
    test_branch_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
